uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, fixed baud rate derived from the system clock.
- Receive-side counterpart of the team's UART transmitter; same CLK_FREQ/BAUD_RATE parameterisation, so a TxD line can be looped straight into RxD.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin (Basys3 USB-UART) and the CPU's I/O logic.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- CNT_DIV (localparam), CLK_FREQ/BAUD_RATE: clocks per bit (10416 at defaults). HALF_DIV = CNT_DIV/2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- RxD  input  1  asynchronous serial input; idles high.
- data  output  8  last correctly received byte, LSB received first.
- valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, data=0, valid=0, frame_err=0, busy=0, both sync flops=1, bit/baud counters=0, shift register=0. Reset mid-frame aborts the frame; nothing is output.
- Input path: 2-flop synchronizer gives rx_s, adding 2 cycles of latency. All decisions use rx_s only.
- Baud counter: width $clog2(CNT_DIV). Cleared on every state entry; otherwise increments by 1 each cycle.
- IDLE: rx_s==0 -> START.
- START: at counter==HALF_DIV-1, sample rx_s.
  - 0 -> DATA, bit index = 0.
  - 1 -> IDLE (glitch rejected; no strobe).
- DATA: at counter==CNT_DIV-1 (mid-bit), shift rx_s into shift[bit], counter cleared.
  - After bit 7 -> STOP; otherwise bit index increments.
- STOP: at counter==CNT_DIV-1, sample rx_s.
  - 1 -> data<=shift, valid=1 for exactly that cycle, next state IDLE.
  - 0 -> frame_err=1 for one cycle, data unchanged, next state BREAK.
- BREAK: wait until rx_s==1, then IDLE. A held-low line (break) produces exactly one frame_err and never retriggers.
- valid and frame_err are never high in the same cycle. Both are registered outputs.
- Latency: valid is asserted 2 + HALF_DIV + 9*CNT_DIV cycles (+/-2) after the RxD falling edge of the start bit.
- Back-to-back frames: a new start edge seen in IDLE the cycle after the STOP sample is accepted, with no dead time beyond the half stop bit.
- data holds its value until the next valid frame; there is no handshake or overrun detection.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each data, start and stop sample is the 2-of-3 majority of rx_s taken at counter = mid-1, mid and mid+1 (mid = HALF_DIV-1 for start, CNT_DIV-1 otherwise; mid+1 observed as counter 0 of the next period). The decision is made at mid+1, so every state advance and the valid/frame_err strobes shift 1 cycle later. A single-cycle glitch at mid-bit is ignored.
- Not defined: a single sample at mid; a glitch exactly at mid corrupts that bit.

Test Plan (CLK_FREQ=960000, BAUD_RATE=9600 -> CNT_DIV=100, HALF_DIV=50):
- Drive frame 0x55 (start 0, LSB first, stop 1, 100 cycles per bit) -> single valid pulse about 952 cycles after the start edge, data=0x55, frame_err never high, busy high throughout the frame.
- Drive 0xA3 then 0x0F with no idle gap -> two valid pulses roughly 1000 cycles apart, data=0xA3 then 0x0F.
- Drive a 30-cycle low glitch on an idle line -> no valid, no frame_err, busy returns to 0 within 55 cycles.
- Drive 0x3C with stop bit 0, then hold RxD low for 3000 cycles, then release -> exactly one frame_err pulse, data keeps its previous value, busy stays 1 until RxD high, then a following 0x81 frame receives correctly.
- Assert rst for one cycle during bit 4 of a frame -> all outputs 0 next cycle; no valid for the aborted frame; the next full frame 0xC6 receives correctly.
- Majority-vote builds: invert RxD for 1 cycle at the mid-sample of bit 2 of 0x00 -> with UART_RX_MAJORITY_EN data=0x00; without it data=0x04.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a fixed baud rate derived from clk.
// Samples the middle of each bit after a 2-flop synchronizer, delivers each
// good byte with a one-cycle valid strobe and flags a low stop bit as a
// framing error. A held-low line (break) is reported once and then ignored
// until the line returns high.
// Optional build macro: UART_RX_MAJORITY_EN -- each start/data/stop decision
// becomes a 2-of-3 vote over mid-1, mid and mid+1, one cycle later.

module uart_receiver #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = CNT_DIV / 2;
  localparam int CW       = $clog2(CNT_DIV);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q;
  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;

  logic          rx_s;
  logic          at_mid;   // counter sits on the nominal mid-bit sample point
  logic          smp_stb;  // a bit decision is taken this cycle
  logic          smp_val;  // value of that decision

  assign rx_s = sync2_q;

  // Mid-bit sample point for the current state.
  always_comb begin
    at_mid = 1'b0;
    case (state_q)
      S_START:        at_mid = (cnt_q == HALF_LAST);
      S_DATA, S_STOP: at_mid = (cnt_q == CNT_LAST);
      default:        at_mid = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] HALF_PRE = CW'(HALF_DIV - 2);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CNT_DIV - 2);

  logic pre_q;   // rx_s one cycle before mid
  logic mid_q;   // rx_s at mid
  logic pend_q;  // mid was seen last cycle; vote now with the mid+1 sample
  logic at_pre;

  // Sample point one cycle ahead of mid, and the 2-of-3 vote at mid+1.
  always_comb begin
    at_pre = 1'b0;
    case (state_q)
      S_START:        at_pre = (cnt_q == HALF_PRE);
      S_DATA, S_STOP: at_pre = (cnt_q == CNT_PRE);
      default:        at_pre = 1'b0;
    endcase
    smp_stb = pend_q;
    smp_val = (pre_q & mid_q) | (pre_q & rx_s) | (mid_q & rx_s);
  end

  // Capture the first two votes; the third is the live rx_s at mid+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= 1'b0;
      mid_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (at_pre) pre_q <= rx_s;
      if (at_mid) mid_q <= rx_s;
      pend_q <= at_mid;
    end
  end
`else
  // Single sample taken exactly at mid-bit.
  always_comb begin
    smp_stb = at_mid;
    smp_val = rx_s;
  end
`endif

  // Synchronizer, baud counter, frame FSM and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      // NOTE: sync flops reset to the idle line level so release from reset
      // cannot look like a start edge.
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= RxD;
      sync2_q     <= sync1_q;
      // NOTE: strobes default low every cycle so a set below lasts exactly
      // one clock; the later assignment in the case wins.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      // The bit period restarts at every mid-bit point, so successive samples
      // stay exactly CNT_DIV apart even when the vote lands one cycle later.
      cnt_q       <= at_mid ? '0 : cnt_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end

        S_START: begin
          if (smp_stb) begin
            if (!smp_val) begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end else begin
              state_q <= S_IDLE;  // too short to be a start bit
            end
          end
        end

        S_DATA: begin
          if (smp_stb) begin
            shift_q[bit_q] <= smp_val;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end

        S_STOP: begin
          if (smp_stb) begin
            if (smp_val) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at CLK_FREQ=960000, BAUD_RATE=9600
// (100 clocks per bit). RxD is driven 1 time unit after a rising edge, and
// outputs are observed either mid-cycle by the negedge monitor or 1 unit
// after a rising edge.

module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(
    .CLK_FREQ (960000),
    .BAUD_RATE(9600)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RxD      (RxD),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor: counts strobes on the falling edge.
  int         neg_cnt   = 0;
  int         valid_cnt = 0;
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  int         busy_low  = 0;
  int         frame_t0  = 0;
  int         valid_t[$];
  logic [7:0] valid_d[$];

  always @(negedge clk) begin
    neg_cnt++;
    if (valid === 1'b1) begin
      valid_cnt++;
      valid_t.push_back(neg_cnt);
      valid_d.push_back(data);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Hold RxD at v for n clock periods; returns 1 unit after a rising edge.
  task automatic drive_level(input logic v, input int n);
    RxD = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame, 100 cycles per bit. glitch_n >= 0 inverts the line for
  // that single cycle of the frame. Busy is probed at each bit boundary.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_n);
    logic lvl;
    frame_t0 = neg_cnt;
    for (int n = 0; n < 1000; n++) begin
      int bi;
      bi = n / 100;
      if (bi == 0)      lvl = 1'b0;
      else if (bi == 9) lvl = stop;
      else              lvl = b[bi-1];
      if (n == glitch_n) lvl = ~lvl;
      if ((n % 100 == 0) && n >= 100 && n <= 900 && busy !== 1'b1) busy_low++;
      RxD = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    drive_level(1'b1, 5);
  endtask

  task automatic test_single();
    int v0, f0, b0, lat;
    v0 = valid_cnt; f0 = fe_cnt; b0 = busy_low;
    send_frame(8'h55, 1'b1, -1);
    drive_level(1'b1, 20);
    checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL single_valid_count got=%0d exp=%0d", valid_cnt - v0, 1); end
    checks++; if (data !== 8'h55) begin errors++; $display("FAIL single_data got=%h exp=55", data); end
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL single_frame_err got=%0d exp=0", fe_cnt - f0); end
    checks++; if (busy_low != b0) begin errors++; $display("FAIL single_busy_in_frame low_probes=%0d exp=0", busy_low - b0); end
    lat = (valid_t.size() > 0) ? valid_t[$] - frame_t0 : -1;
    checks++; if (lat < 950 || lat > 955) begin errors++; $display("FAIL single_latency got=%0d exp=950..955", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int v0, sz;
    v0 = valid_cnt;
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    drive_level(1'b1, 20);
    checks++; if (valid_cnt != v0 + 2) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
    sz = valid_d.size();
    checks++;
    if (sz < 2) begin
      errors++; $display("FAIL b2b_bytes got=%0d strobes exp>=2", sz);
    end else begin
      if (valid_d[sz-2] !== 8'hA3 || valid_d[sz-1] !== 8'h0F) begin
        errors++; $display("FAIL b2b_bytes got=%h,%h exp=a3,0f", valid_d[sz-2], valid_d[sz-1]);
      end
      checks++;
      if (valid_t[sz-1] - valid_t[sz-2] != 1000) begin
        errors++; $display("FAIL b2b_spacing got=%0d exp=1000", valid_t[sz-1] - valid_t[sz-2]);
      end
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    drive_level(1'b0, 30);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during got=%b exp=1", busy); end
    drive_level(1'b1, 25);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_release got=%b exp=0", busy); end
    drive_level(1'b1, 20);
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    drive_level(1'b0, 3000);
    checks++; if (fe_cnt != f0 + 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - f0); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (data !== 8'h0F) begin errors++; $display("FAIL ferr_data_kept got=%h exp=0f", data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break got=%b exp=1", busy); end
    drive_level(1'b1, 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
    checks++; if (fe_cnt != f0 + 1) begin errors++; $display("FAIL ferr_no_retrigger got=%0d exp=1", fe_cnt - f0); end
    send_frame(8'h81, 1'b1, -1);
    drive_level(1'b1, 20);
    checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL ferr_recover_valid got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL ferr_recover_data got=%h exp=81", data); end
  endtask

  // Frame 0xF5 is aborted halfway through bit 4; bits 4..7 and stop are all
  // high, so the rest of the aborted frame looks like an idle line.
  task automatic test_reset_midframe();
    int v0;
    v0 = valid_cnt;
    drive_level(1'b0, 100);  // start
    drive_level(1'b1, 100);  // bit 0
    drive_level(1'b0, 100);  // bit 1
    drive_level(1'b1, 100);  // bit 2
    drive_level(1'b0, 100);  // bit 3
    drive_level(1'b1, 50);   // first half of bit 4
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL abort_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    drive_level(1'b1, 500);
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", valid_cnt - v0); end
    send_frame(8'hC6, 1'b1, -1);
    drive_level(1'b1, 20);
    checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL abort_next_valid got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data !== 8'hC6) begin errors++; $display("FAIL abort_next_data got=%h exp=c6", data); end
  endtask

  // One-cycle inversion at the mid-sample of bit 2 (frame cycle 350).
  task automatic test_majority();
    int v0;
    logic [7:0] exp_b;
`ifdef UART_RX_MAJORITY_EN
    exp_b = 8'h00;
`else
    exp_b = 8'h04;
`endif
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, 350);
    drive_level(1'b1, 20);
    checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL midglitch_valid got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data !== exp_b) begin errors++; $display("FAIL midglitch_data got=%h exp=%h", data, exp_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_majority();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_exclusive got=%0d overlaps exp=0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
